// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: single-cycle AND/OR/ADD/SUB, iterative shift-add MUL and restoring DIV.
// Optional MUL/DIV datapath is built only when ALU_MULDIV_EN is defined; otherwise those codes act as NOP.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: a request is taken on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and out_valid is a single-cycle pulse per accepted request.
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;

`ifdef ALU_MULDIV_EN
  localparam logic [3:0] CTRL_MUL = 4'b1000;
  localparam logic [3:0] CTRL_DIV = 4'b1100;
  localparam int         CW       = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd3} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] alu_res;

  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] ctrl,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (ctrl)
      CTRL_AND: alu_op = a & b;
      CTRL_OR:  alu_op = a | b;
      CTRL_ADD: alu_op = a + b;
      CTRL_SUB: alu_op = a - b;
      default:  alu_op = '0;
    endcase
  endfunction

  always_comb alu_res = alu_op(alu_ctrl, op_a, op_b);

  assign state_dbg = state;

`ifdef ALU_MULDIV_EN
  // acc: product accumulator (MUL) or partial remainder (DIV).
  // opa_q: shifting multiplicand (MUL) or dividend/quotient shift register (DIV).
  // opb_q: shifting multiplier (MUL) or fixed divisor (DIV).
  logic [WIDTH-1:0] acc, opa_q, opb_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mul_acc_nx, div_rem_nx, div_quo_nx;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;

  always_comb begin
    mul_acc_nx = opb_q[0] ? (acc + opa_q) : acc;
    div_sh     = {acc, opa_q[WIDTH-1]};
    div_ge     = (div_sh >= {1'b0, opb_q});
    // A successful trial subtraction is always below the divisor, so WIDTH bits hold it.
    div_rem_nx = div_ge ? (div_sh[WIDTH-1:0] - opb_q) : div_sh[WIDTH-1:0];
    div_quo_nx = {opa_q[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      result      <= '0;
      out_valid   <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            in_ready <= 1'b0;
            acc      <= '0;
            opa_q    <= op_a;
            opb_q    <= op_b;
            cnt      <= '0;
            if (alu_ctrl == CTRL_MUL) begin
              state <= S_MUL;
            end else if (alu_ctrl == CTRL_DIV) begin
              state <= S_DIV;
            end else begin
              result      <= alu_res;
              zero        <= (alu_res == '0);
              div_by_zero <= 1'b0;
              out_valid   <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc   <= mul_acc_nx;
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            result      <= mul_acc_nx;
            zero        <= (mul_acc_nx == '0);
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DIV: begin
          if (opb_q == '0) begin
            result      <= '1;
            zero        <= 1'b0;
            div_by_zero <= 1'b1;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end else begin
            acc   <= div_rem_nx;
            opa_q <= div_quo_nx;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              result      <= div_quo_nx;
              zero        <= (div_quo_nx == '0);
              div_by_zero <= 1'b0;
              out_valid   <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end
`else
  assign div_by_zero = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      result    <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            in_ready  <= 1'b0;
            result    <= alu_res;
            zero      <= (alu_res == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboarded bench for alu_exec_unit: directed vectors, expected {div_by_zero, zero, result} and completion cycle queued at issue.
// Expectations follow ALU_MULDIV_EN the same way the design does.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] op_a, op_b;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] result;
  logic         out_valid;
  logic         zero;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  logic [W+1:0] exp_q[$];
  int           cyc_q[$];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .in_valid(in_valid), .in_ready(in_ready), .result(result), .out_valid(out_valid),
    .zero(zero), .div_by_zero(div_by_zero), .state_dbg(state_dbg)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every out_valid pulse must match the oldest expectation, at the expected cycle
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got result=%h at cycle %0d, required no output", result, cyc);
      end else begin
        logic [W+1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        checks++;
        if ({div_by_zero, zero, result} !== e) begin
          failures++;
          $display("FAIL result: got dbz=%b zero=%b result=%h, required dbz=%b zero=%b result=%h",
                   div_by_zero, zero, result, e[W+1], e[W], e[W-1:0]);
        end
        checks++;
        if (cyc != ec) begin
          failures++;
          $display("FAIL latency: out_valid at cycle %0d, required cycle %0d", cyc, ec);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Driver: waits for in_ready, presents one request for one edge, then scrambles operands
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic ez, input logic edbz,
                       input int lat, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    if (push) begin
      exp_q.push_back({edbz, ez, r});
      cyc_q.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    alu_ctrl = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst      = 1'b1;
    alu_ctrl = 4'h0;
    op_a     = '0;
    op_b     = '0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", W'(in_ready), 32'd1);
    check("reset_result", result, 32'd0);
    check("reset_out_valid", W'(out_valid), 32'd0);
    check("reset_zero", W'(zero), 32'd0);
    check("reset_div_by_zero", W'(div_by_zero), 32'd0);
    check("reset_state", W'(state_dbg), 32'd0);
    rst = 1'b0;

    // Single-cycle ALU operations
    issue(4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1, 1'b1);
    issue(4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 1'b1);
    issue(4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    issue(4'b0000, 32'hF0, 32'h0F, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    issue(4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1, 1'b1);
    issue(4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0, 1, 1'b1);
    issue(4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b1);
    issue(4'b0000, 32'hA5A5_A5A5, 32'h0FF0_0FF0, 32'h05A0_05A0, 1'b0, 1'b0, 1, 1'b1);
    issue(4'b0001, 32'h1234_5678, 32'h8000_0001, 32'h9234_5679, 1'b0, 1'b0, 1, 1'b1);

`ifdef ALU_MULDIV_EN
    begin
      int busy_bad = 0;
      issue(4'b1000, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, 33, 1'b1);
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        if (in_ready) busy_bad++;
        if (i == 10) begin
          alu_ctrl = 4'b0010;
          op_a     = 32'd1;
          op_b     = 32'd1;
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      check("mul_busy_in_ready_high_cycles", W'(busy_bad), 32'd0);
    end
    issue(4'b1000, 32'd0, 32'd5, 32'd0, 1'b1, 1'b0, 33, 1'b1);
    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 33, 1'b1);
    issue(4'b1100, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, 1'b1);
    issue(4'b1100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, 1'b1);
    issue(4'b1100, 32'd5, 32'd9, 32'd0, 1'b1, 1'b0, 33, 1'b1);
    issue(4'b1100, 32'd42, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2, 1'b1);
    issue(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1, 1'b1);
`else
    issue(4'b1000, 32'd1234, 32'd5678, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    issue(4'b1000, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    issue(4'b0010, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1, 1'b1);
    issue(4'b1100, 32'd100, 32'd7, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    issue(4'b1100, 32'd42, 32'd0, 32'd0, 1'b1, 1'b0, 1, 1'b1);
`endif

    // Undefined control code behaves as NOP
    issue(4'b1111, 32'hFFFF, 32'hFFFF, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    issue(4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1, 1'b1);
    drain();

    // Reset discards work in flight and clears the held result
`ifdef ALU_MULDIV_EN
    issue(4'b1000, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0, 33, 1'b0);
    repeat (9) @(negedge clk);
`endif
    rst = 1'b1;
    @(negedge clk);
    check("rst_state", W'(state_dbg), 32'd0);
    check("rst_in_ready", W'(in_ready), 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_out_valid", W'(out_valid), 32'd0);
    check("rst_div_by_zero", W'(div_by_zero), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    check("outstanding_at_end", W'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
